// File: rtl/data_sram_resp.sv
// Word-organised data SRAM with byte write enables and a configurable number
// of stall cycles per access; load data is registered for the MEM stage.
module data_sram_resp #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [2:0] WAIT_M1 = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [ADDR_W-1:0] idx_in, idx_lat, acc_idx;
    logic [3:0]        wen_lat, acc_wen;
    logic [31:0]       wdata_lat, acc_wdata;
    logic              accept, acc_go;
    logic              unused_addr;
    logic [31:0]       mem [2**ADDR_W];

    // Byte offset and bits above the array size are dropped, so addresses alias.
    assign idx_in      = data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (data_sram_en && (WAIT != 0)) begin
                    state_nxt = BUSY;
                    cnt_nxt   = WAIT_M1;
                end
            end
            BUSY: begin
                if (cnt == 3'd0) state_nxt = IDLE;
                else             cnt_nxt   = 3'(cnt - 3'd1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With no wait states the live request is the access; otherwise the latched one.
    always_comb begin
        stallreq  = (state == BUSY);
        accept    = (state == IDLE) && data_sram_en;
        acc_go    = 1'b0;
        acc_idx   = idx_lat;
        acc_wen   = wen_lat;
        acc_wdata = wdata_lat;
        if (WAIT == 0) begin
            acc_go    = resetn && accept;
            acc_idx   = idx_in;
            acc_wen   = data_sram_wen;
            acc_wdata = data_sram_wdata;
        end else begin
            acc_go = resetn && (state == BUSY) && (cnt == 3'd0);
        end
    end

    always_ff @(posedge clk) begin
        if (accept && resetn) begin
            idx_lat   <= idx_in;
            wen_lat   <= data_sram_wen;
            wdata_lat <= data_sram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_go) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wen[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= 32'h0;
        end else if (acc_go && (acc_wen == 4'b0000)) begin
            data_sram_rdata <= mem[acc_idx];
        end
    end

endmodule

// File: doc/data_sram_resp.md
DATA_SRAM_RESP -- requirements
Module: data_sram_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning log2 of the number of 32-bit words in the array.
REQ-002 SHALL have parameter WAIT, default 0, range 0..7, meaning the number of stall cycles inserted per access.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port data_sram_en, input, 1 bit: access request from the EX stage.
REQ-006 SHALL have port data_sram_wen, input, 4 bits: byte write enables; 4'b0000 with en=1 means read.
REQ-007 SHALL have port data_sram_addr, input, 32 bits: byte address.
REQ-008 SHALL have port data_sram_wdata, input, 32 bits: store data, lane i = bits [8i+7:8i].
REQ-009 SHALL have port data_sram_rdata, output, 32 bits: registered load data consumed by the MEM stage.
REQ-010 SHALL have port stallreq, output, 1 bit: stall request to the pipeline stall controller, driven high while an access is in progress.

Function
REQ-011 SHALL implement a two-state FSM with states IDLE and BUSY, plus a 3-bit wait counter cnt.
REQ-012 SHALL accept a request on a rising edge where state==IDLE and data_sram_en==1, latching addr, wen and wdata.
REQ-013 SHALL, with WAIT==0, perform the access on the accept edge and remain in IDLE, so load data is valid in the cycle after the accept edge.
REQ-014 SHALL, with WAIT>0, enter BUSY on the accept edge with cnt=WAIT-1.
REQ-015 SHALL, in BUSY with cnt!=0, decrement cnt each edge.
REQ-016 SHALL, in BUSY with cnt==0, perform the latched access on that edge and return to IDLE.
REQ-017 SHALL give load data valid on data_sram_rdata exactly WAIT+1 cycles after the accept edge.
REQ-018 SHALL drive stallreq combinationally as (state==BUSY), so it is high for exactly WAIT cycles per access.
REQ-019 SHALL ignore en, wen, addr and wdata while in BUSY.
REQ-020 SHALL accept a request presented in the first IDLE cycle after BUSY normally.
REQ-021 SHALL use word index addr[ADDR_W+1:2]; addr[1:0] and bits above ADDR_W+1 SHALL be ignored, so higher addresses alias.
REQ-022 SHALL, on a write, update only the bytes whose wen bit is 1; all other bytes are unchanged.
REQ-023 SHALL, on a read, load rdata with the full 32-bit word; byte/half selection and sign extension are not done by this block.
REQ-024 SHALL make rdata hold its last loaded value on write accesses, idle cycles and BUSY cycles.
REQ-025 SHALL return the newly written value for a read issued after a write to the same word (no stale data).
REQ-026 SHALL leave the array contents unaffected by reset; array contents are undefined until written.

Reset
REQ-027 SHALL, while resetn==0, force state=IDLE, cnt=0, rdata=32'h0 and stallreq=0, independent of clk.
REQ-028 SHALL, if reset asserts during BUSY, abort the access; a pending write SHALL NOT modify the array.
REQ-029 SHALL accept the first request on the first rising edge after resetn deasserts.

Verification
REQ-030 SHALL cover: WAIT=0, write 32'hDEADBEEF wen=4'hF at addr 0x10, then read 0x10 -> rdata=32'hDEADBEEF one cycle after the read edge, stallreq never high.
REQ-031 SHALL cover: WAIT=0, word 0x10=32'hDEADBEEF, write wen=4'b0101 wdata=32'h11223344 at 0x10, then read -> rdata=32'hDE22BE44.
REQ-032 SHALL cover: WAIT=3, read accepted at edge t0 -> stallreq high for exactly 3 cycles, rdata valid after edge t3, changes to en during BUSY have no effect.
REQ-033 SHALL cover: ADDR_W=10, write 32'hA5A5A5A5 at 0x0000_1004, read 0x0000_0004 -> rdata=32'hA5A5A5A5 (aliasing).
REQ-034 SHALL cover: WAIT=2, write to 0x20 (prior value 32'h0), resetn pulsed low during BUSY -> stallreq=0 and rdata=0 immediately, later read of 0x20 returns 32'h0.
REQ-035 SHALL cover: WAIT=1, back-to-back requests with en held high -> second request accepted on the first IDLE edge, stallreq pattern 1,0,1.
